// File: rtl/cipher_sequencer.sv
// Sequencer for the bus-based string cipher: walks memory element by element, transforming in place.
// Optional abort input enabled by defining CIPHER_SEQUENCER_ABORT_EN.
module cipher_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int ROUNDS_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ROUNDS_W-1:0] rounds,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef CIPHER_SEQUENCER_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   index,
  output logic [ADDR_W:0]     length,
  output logic                decrypt_sel,
  output logic                index_drive,
  output logic                address_write,
  output logic                memory_drive,
  output logic                memory_write,
  output logic                element_write,
  output logic                element_drive
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_XFORM    = 3'd3;
  localparam logic [2:0] S_INCR     = 3'd4;
  localparam logic [2:0] S_PASS_END = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [ROUNDS_W-1:0] rounds_q;
  logic [ROUNDS_W-1:0] pass_cnt;
  logic                abort_hit;

`ifdef CIPHER_SEQUENCER_ABORT_EN
  // DONE is excluded so a run that already finished still reports completion.
  assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_ADDR;
      S_ADDR:     state_nxt = S_CHECK;
      S_CHECK:    state_nxt = (mem_rdata == '0) ? S_PASS_END : S_XFORM;
      S_XFORM:    state_nxt = S_INCR;
      S_INCR:     state_nxt = (index == LAST_INDEX) ? S_PASS_END : S_ADDR;
      S_PASS_END: state_nxt = (pass_cnt == rounds_q) ? S_DONE : S_ADDR;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      index       <= '0;
      length      <= '0;
      pass_cnt    <= '0;
      rounds_q    <= '0;
      decrypt_sel <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            decrypt_sel <= mode;
            rounds_q    <= rounds;
            index       <= '0;
            length      <= '0;
            pass_cnt    <= '0;
          end
        end
        // The write-back happens in this cycle regardless of abort, so count it.
        S_XFORM: length <= length + 1'b1;
        S_INCR: begin
          if (!abort_hit && (index != LAST_INDEX)) index <= index + 1'b1;
        end
        S_PASS_END: begin
          if (!abort_hit && (pass_cnt != rounds_q)) begin
            pass_cnt <= pass_cnt + 1'b1;
            index    <= '0;
            length   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    index_drive   = (state == S_ADDR);
    address_write = (state == S_ADDR);
    memory_drive  = (state == S_CHECK) || (state == S_XFORM);
    memory_write  = (state == S_XFORM);
    element_write = (state == S_XFORM);
    element_drive = (state == S_XFORM);
  end

endmodule

// File: tb/tb_cipher_sequencer.sv
// Self-checking bench for cipher_sequencer: memory model with a +1/-1 element transform,
// pass-level reference model, directed and randomized runs.
module tb_cipher_sequencer;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] rounds = '0;
  logic [7:0] mem_rdata;
  logic       abort = 1'b0;
  logic       busy, done, decrypt_sel;
  logic [3:0] index;
  logic [4:0] length;
  logic       index_drive, address_write, memory_drive, memory_write, element_write, element_drive;

  logic [7:0] tbmem [DEPTH];
  logic [7:0] exp_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  cipher_sequencer #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8), .ROUNDS_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .rounds(rounds),
    .mem_rdata(mem_rdata),
`ifdef CIPHER_SEQUENCER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .index(index), .length(length), .decrypt_sel(decrypt_sel),
    .index_drive(index_drive), .address_write(address_write), .memory_drive(memory_drive),
    .memory_write(memory_write), .element_write(element_write), .element_drive(element_drive)
  );

  always #5 clock = ~clock;

  assign mem_rdata = tbmem[index];

  function automatic logic [7:0] xf(input logic [7:0] x, input logic md);
    return md ? x - 8'd1 : x + 8'd1;
  endfunction

  // Element unit: read-modify-write in the XFORM cycle.
  always @(posedge clock)
    if (memory_write && element_write) tbmem[index] <= xf(tbmem[index], decrypt_sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pass-level reference: each pass scans from 0 until a zero or the end of memory.
  function automatic void model_run(input logic md, input int rnd,
                                    output int d, output int x, output int l, output int ix);
    int tot = 0;
    x = 0; l = 0; ix = 0;
    for (int p = 0; p <= rnd; p++) begin
      int n = 0;
      while (n < DEPTH && exp_mem[n] != 8'd0) begin
        exp_mem[n] = xf(exp_mem[n], md);
        n++;
      end
      tot += (n < DEPTH) ? 4 * n + 3 : 4 * DEPTH + 1;
      x += n;
      l = n;
      ix = (n < DEPTH) ? n : DEPTH - 1;
    end
    d = tot + 1;
  endfunction

  task automatic run_case(input string tag, input logic md, input int rnd, input bit disturb);
    int exp_d, exp_x, exp_l, exp_i;
    int c = 0, done_c = -1, ndone = 0, nxf = 0, bad = 0;
    logic busy1 = 1'b0;
    logic [3:0] idx1 = '1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = tbmem[i];
    model_run(md, rnd, exp_d, exp_x, exp_l, exp_i);
    @(posedge clock); #1;
    mode = md; rounds = 2'(rnd); start = 1'b1;
    while (c < 400 && done_c < 0) begin
      @(posedge clock); c++; #1;
      start = 1'b0;
      if (disturb && c == 5) begin start = 1'b1; mode = ~md; end
      @(negedge clock);
      if (c == 1) begin busy1 = busy; idx1 = index; end
      if (memory_write) nxf++;
      if (done) begin ndone++; done_c = c; end
    end
    start = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_busy_c1"}, busy1, 1);
    chk({tag, "_index_c1"}, idx1, 0);
    chk({tag, "_done_cycle"}, done_c, exp_d);
    chk({tag, "_done_count"}, ndone, 1);
    chk({tag, "_xform_count"}, nxf, exp_x);
    chk({tag, "_length"}, length, exp_l);
    chk({tag, "_index"}, index, exp_i);
    chk({tag, "_decrypt_sel"}, decrypt_sel, md);
    for (int i = 0; i < DEPTH; i++) if (tbmem[i] !== exp_mem[i]) bad++;
    chk({tag, "_mem_errs"}, bad, 0);
    mode = 1'b0;
  endtask

  task automatic load_abc();
    for (int i = 0; i < DEPTH; i++) tbmem[i] = 8'h00;
    tbmem[0] = 8'h41; tbmem[1] = 8'h42; tbmem[2] = 8'h43;
  endtask

  initial begin
    int seen;
    load_abc();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_index", index, 0);
    chk("rst_length", length, 0);
    chk("rst_dsel", decrypt_sel, 0);
    chk("rst_strobes", {index_drive, address_write, memory_drive, memory_write, element_write, element_drive}, 0);
    reset_n = 1'b1;

    run_case("abc", 1'b0, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) tbmem[i] = 8'($urandom_range(3, 255));
    run_case("full", 1'b1, 1, 1'b0);

    for (int i = 0; i < DEPTH; i++) tbmem[i] = 8'($urandom_range(1, 255));
    tbmem[0] = 8'h00;
    run_case("zero_first", 1'b0, 3, 1'b0);

    load_abc();
    run_case("disturb", 1'b0, 0, 1'b1);

    // Asynchronous reset in the middle of an XFORM cycle.
    load_abc();
    @(posedge clock); #1;
    mode = 1'b1; rounds = 2'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clock);
      if (memory_write) seen = 1;
    end
    chk("rst_mid_seen_xform", seen, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_index", index, 0);
    chk("rst_mid_length", length, 0);
    chk("rst_mid_dsel", decrypt_sel, 0);
    chk("rst_mid_strobes", {done, index_drive, address_write, memory_drive, memory_write, element_write, element_drive}, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (done || busy) seen = 1;
    end
    chk("rst_mid_quiet", seen, 0);
    reset_n = 1'b1;
    mode = 1'b0;
    run_case("after_rst", 1'b0, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++)
        tbmem[i] = ($urandom_range(0, 9) < 2) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      run_case($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef CIPHER_SEQUENCER_ABORT_EN
    load_abc();
    @(posedge clock); #1;
    mode = 1'b0; rounds = 2'd0; start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      abort = (c == 6);
      @(negedge clock);
      if (done) seen = 1;
      if (c == 7) begin
        chk("abort_busy_c7", busy, 0);
        chk("abort_length", length, 1);
      end
    end
    abort = 1'b0;
    chk("abort_no_done", seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_sequencer.md
# cipher_sequencer

Parametrised sequencer for the bus-based string cipher datapath. It walks a memory of DEPTH elements and transforms each one in place, element by element, until it reaches a zero terminator or the end of memory. It can repeat the walk for several passes, in encrypt or decrypt mode, and uses a start/busy/done handshake. The index counter and terminator detection are internal, so the datapath only supplies the read data bus.

## Interface
- DEPTH, 16: number of memory elements; 1 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 4: index/address width
- DATA_W, 8: element width
- ROUNDS_W, 2: width of pass-count input
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- mode  in  1  0 = encrypt, 1 = decrypt; latched at start
- rounds  in  ROUNDS_W  passes minus one; latched at start
- mem_rdata  in  DATA_W  memory element currently driven on the bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion
- index  out  ADDR_W  current element index
- length  out  ADDR_W+1  elements transformed in the current or last pass
- decrypt_sel  out  1  latched mode, steers the element unit
- index_drive, address_write, memory_drive, memory_write, element_write, element_drive  out  1 each  datapath bus strobes

## Operation
- State is registered. Strobes, busy and done are Moore outputs decoded from state.
- IDLE: all strobes 0. If start = 1: latch mode and rounds, clear index, length and the pass counter, then go to ADDR.
- ADDR: index_drive = 1 and address_write = 1. Go to CHECK.
- CHECK: memory_drive = 1.
  - mem_rdata == 0: go to PASS_END.
  - Otherwise: go to XFORM.
- XFORM: memory_drive, element_write, element_drive and memory_write all = 1. The element is read, transformed and written back in this cycle. length increments. Go to INCR.
- INCR: no strobes.
  - index == DEPTH-1: go to PASS_END.
  - Otherwise: index increments, then go to ADDR.
- PASS_END:
  - pass counter == latched rounds: go to DONE.
  - Otherwise: pass counter increments, index and length clear, then go to ADDR.
- DONE: done = 1 and busy = 1. Go to IDLE. index and length hold until the next start.
- start outside IDLE is ignored. mode and rounds changes during a run are ignored.
- index never wraps: the pass ends at DEPTH-1 before any increment.

## Timing
- Reset values: state IDLE. index, length, pass counter and decrypt_sel = 0. All strobes, busy and done = 0.
- Reset is asynchronous: asserting it mid-run forces IDLE and all outputs 0 immediately. No done is produced.
- Cycle 0 is the IDLE cycle in which start = 1. busy rises at cycle 1.
- Pass length P:
  - Terminator found after n transformed elements (n < DEPTH): P = 4n + 3.
  - No terminator: P = 4·DEPTH + 1.
- done is high in cycle (rounds+1)·P + 1. IDLE is re-entered one cycle later.
- A zero first element gives P = 3 and length = 0.
- Every pass rescans from index 0. Transformed data, including any newly zero element, is re-checked on each pass.

## Configuration
- CIPHER_SEQUENCER_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort = 1 in any busy state other than DONE forces IDLE at the next edge.
  - No done pulse. index and length hold.
  - A strobe cycle in progress completes normally. No further strobes are issued.
- Macro undefined: the port is absent and runs always complete.

## Test plan
- DEPTH=16, rounds=0, mode=0, memory "ABC\0..." → three XFORM cycles, length=3, done in cycle 16, decrypt_sel=0.
- DEPTH=16, no zero element, rounds=1, mode=1 → 32 XFORM cycles, index never exceeds 15, length=16, done in cycle 131, decrypt_sel=1.
- First element 0, rounds=3 → no XFORM cycles, length=0, done in cycle 13.
- start pulsed again at cycle 5 of a run, and mode toggled mid-run → ignored; run timing and decrypt_sel unchanged.
- reset_n driven low during an XFORM cycle → all outputs 0 immediately, no done. A later start begins again at index 0.
- With CIPHER_SEQUENCER_ABORT_EN: abort at cycle 6 → IDLE at cycle 7, busy=0, done never asserted, length holds its value.
